// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter for a register file, with an init sequencer
// that sweeps every address with INIT_VALUE on command. The rf_* outputs are
// registered and connect directly to the register file's write port.
module rf_write_arbiter #(
  parameter int                    NUM_REQ    = 2,
  parameter int                    ADDR_WIDTH = 1,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_start,
  output logic                          init_busy,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_write_enable,
  output logic [ADDR_WIDTH-1:0]         rf_addr,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [GW-1:0]           gid_q, gid_d;

  logic                    found;
  logic [GW-1:0]           winner;
  logic                    xfer;
  logic [NUM_REQ-1:0]      grant_vec;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A grant is only offered in RUN when no init sweep is being requested;
  // init_start wins over any pending request. Held low while in reset.
  always_comb begin
    xfer      = (state_q == ST_RUN) && !init_start && found;
    grant_vec = '0;
    if (xfer && reset) grant_vec[winner] = 1'b1;
  end

  assign req_ready = grant_vec;

  // Next-state logic for the FSM, pointer, init counter and write-port register.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    init_cnt_d = init_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    gid_d      = gid_q;
    case (state_q)
      ST_RUN: begin
        if (init_start) begin
          state_d = ST_INIT;
        end else if (found) begin
          we_d   = 1'b1;
          addr_d = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          gid_d  = winner;
          // Pointer moves just past the winner so it has lowest priority next.
          rr_ptr_d = (winner == GW'(NUM_REQ - 1)) ? '0 : winner + GW'(1);
        end
      end
      ST_INIT: begin
        we_d   = 1'b1;
        addr_d = init_cnt_q;
        data_d = INIT_VALUE;
        gid_d  = '0;
        if (init_cnt_q == '1) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and write-port registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      init_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      gid_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      init_cnt_q <= init_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gid_q      <= gid_d;
    end
  end

  assign init_busy       = (state_q == ST_INIT);
  assign rf_write_enable = we_q;
  assign rf_addr         = addr_q;
  assign rf_write_data   = data_q;
  assign grant_id        = gid_q;

endmodule
